vga_console: RTL and testbench

VGA_CONSOLE -- requirements
Module: vga_console

---
 rtl/vga_console_pkg.sv | 21 ++
 rtl/vga_console_if.sv | 34 +++
 rtl/vga_console_cursor.sv | 53 +++++
 rtl/vga_console.sv | 123 ++++++++++++
 tb/tb_vga_console.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/vga_console_pkg.sv
// Shared constants and types for the text console (package vga_pkg).
// Holds the control character codes, the console state enum and a printable-range helper.
// Imported by vga_console and vga_cursor; no ports.
package vga_pkg;

  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_BS    = 8'h08;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } con_state_t;

  // Codes that occupy a cell on screen (space through tilde).
  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/vga_console_if.sv
// Console bus: character input handshake, clear request, buffer write port and status.
// Ports: char_valid/char_data/char_ready, clear_req, wr_en/wr_addr/wr_data, cursor_x/cursor_y, busy.
// Modports: master = requester / buffer side, slave = the console block.
interface vga_console_if #(
  parameter int COLS = 160,
  parameter int ROWS = 128
);

  localparam int ADDR_W = $clog2(COLS * ROWS);
  localparam int XW     = $clog2(COLS);
  localparam int YW     = $clog2(ROWS);

  logic              char_valid;
  logic [7:0]        char_data;
  logic              char_ready;
  logic              clear_req;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [XW-1:0]     cursor_x;
  logic [YW-1:0]     cursor_y;
  logic              busy;

  modport master (
    output char_valid, char_data, clear_req,
    input  char_ready, wr_en, wr_addr, wr_data, cursor_x, cursor_y, busy
  );

  modport slave (
    input  char_valid, char_data, clear_req,
    output char_ready, wr_en, wr_addr, wr_data, cursor_x, cursor_y, busy
  );

endinterface

// File: rtl/vga_console_cursor.sv
// Cursor column/row counters (module vga_cursor) with advance, newline, return, backspace, zero.
// Ports: clk, reset (async active-high), control strobes in; x, y and row-wrap flag out.
// wrap is combinational: high when this cycle's controls push the row past ROWS-1.
module vga_cursor
  import vga_pkg::*;
#(
  parameter int COLS = 160,
  parameter int ROWS = 128
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     adv,   // one column right, wrapping to next row
  input  logic                     nl,    // column 0, next row
  input  logic                     cr,    // column 0, same row
  input  logic                     bs,    // one column left when not at column 0
  input  logic                     zero,  // home to (0,0), overrides everything
  output logic [$clog2(COLS)-1:0]  x,
  output logic [$clog2(ROWS)-1:0]  y,
  output logic                     wrap
);

  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);
  localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);

  logic row_adv;

  // COLS/ROWS need not be powers of two, so both wraps are explicit compares.
  assign row_adv = nl | (adv & (x == X_LAST));
  assign wrap    = row_adv & (y == Y_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (zero) begin
      x <= '0;
      y <= '0;
    end else begin
      if (nl || cr || (adv && (x == X_LAST)))
        x <= '0;
      else if (adv)
        x <= x + XW'(1);
      else if (bs && (x != '0))
        x <= x - XW'(1);

      if (row_adv)
        y <= (y == Y_LAST) ? '0 : y + YW'(1);
    end
  end

endmodule

// File: rtl/vga_console.sv
// Text console writer: turns a character stream into character-buffer writes and tracks the cursor.
// Ports: clk, reset (async active-high), bus (vga_console_if.slave: char handshake, clear_req,
// buffer write port, cursor, busy). Optional macro VGA_CONSOLE_AUTOCLEAR_EN: wrap past the last row clears.
module vga_console
  import vga_pkg::*;
#(
  parameter int COLS = 160,
  parameter int ROWS = 128
) (
  input  logic         clk,
  input  logic         reset,
  vga_console_if.slave bus
);

  localparam int ADDR_W = $clog2(COLS * ROWS);
  localparam int XW     = $clog2(COLS);
  localparam int YW     = $clog2(ROWS);
  localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(COLS * ROWS - 1);

  con_state_t        state;
  logic              accept;
  logic              adv, nl, cr, bs, zero;
  logic              row_wrap;
  logic [XW-1:0]     cx;
  logic [YW-1:0]     cy;
  logic [ADDR_W-1:0] cur_addr;

  // A pending clear request blocks the character in the same cycle.
  assign bus.char_ready = (state == ST_IDLE) && !bus.clear_req;
  assign accept         = bus.char_valid && bus.char_ready;

  assign adv  = accept && is_printable(bus.char_data);
  assign nl   = accept && (bus.char_data == CHAR_LF);
  assign cr   = accept && (bus.char_data == CHAR_CR);
  assign bs   = accept && (bus.char_data == CHAR_BS) && (cx != '0);
  // Home the cursor on the edge that leaves CLEAR.
  assign zero = (state == ST_CLEAR) && (bus.wr_addr == LAST_A);

  // Widen before multiplying so the full row offset survives.
  assign cur_addr = ADDR_W'(cy) * COLS_A + ADDR_W'(cx);

  assign bus.cursor_x = cx;
  assign bus.cursor_y = cy;
  assign bus.busy     = (state == ST_CLEAR);

`ifndef VGA_CONSOLE_AUTOCLEAR_EN
  logic unused_wrap;
  assign unused_wrap = row_wrap;
`endif

  vga_cursor #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_cursor (
    .clk   (clk),
    .reset (reset),
    .adv   (adv),
    .nl    (nl),
    .cr    (cr),
    .bs    (bs),
    .zero  (zero),
    .x     (cx),
    .y     (cy),
    .wrap  (row_wrap)
  );

  // In CLEAR, wr_addr doubles as the clear counter: it is loaded with 0 on
  // entry and steps once per cycle, so CLEAR lasts exactly COLS*ROWS cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          bus.wr_en <= 1'b0;
          if (bus.clear_req) begin
            state       <= ST_CLEAR;
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= '0;
            bus.wr_data <= CHAR_SPACE;
          end
`ifdef VGA_CONSOLE_AUTOCLEAR_EN
          // The screen is about to be blanked, so the wrapping character's
          // own write is dropped and the clear starts straight away.
          else if (row_wrap) begin
            state       <= ST_CLEAR;
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= '0;
            bus.wr_data <= CHAR_SPACE;
          end
`endif
          else if (adv) begin
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= cur_addr;
            bus.wr_data <= bus.char_data;
          end else if (bs) begin
            // Erase the cell the cursor moves back onto (same row, x > 0).
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= cur_addr - ADDR_W'(1);
            bus.wr_data <= CHAR_SPACE;
          end
        end
        ST_CLEAR: begin
          if (bus.wr_addr == LAST_A) begin
            state     <= ST_IDLE;
            bus.wr_en <= 1'b0;
          end else begin
            bus.wr_addr <= bus.wr_addr + ADDR_W'(1);
          end
        end
        default: begin
          state     <= ST_IDLE;
          bus.wr_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_console.sv
// Self-checking bench for vga_console: directed cases plus a random character stream
// checked against a cursor/screen model written with plain integer arithmetic.
// Inputs driven just after the falling edge, outputs sampled on the falling edge.
module tb_vga_console;

  localparam int COLS  = 160;
  localparam int ROWS  = 128;
  localparam int NCELL = COLS * ROWS;

  logic clk;
  logic reset;

  int n_total = 0;
  int n_bad   = 0;

  // Model cursor
  int mx = 0;
  int my = 0;

  vga_console_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

  vga_console #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "time limit");
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rnd_char();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 60)      return 8'($urandom_range(32, 126));
    else if (r < 70) return 8'h0A;
    else if (r < 78) return 8'h0D;
    else if (r < 90) return 8'h08;
    else             return 8'($urandom_range(0, 255));
  endfunction

  // Follow a full-screen clear. Entered at the falling edge of the first clear
  // cycle. abort_at >= 0 asserts reset in that clear cycle instead of finishing.
  task automatic run_clear(input int abort_at);
    int  errs;
    bit  aborted;
    errs    = 0;
    aborted = 1'b0;
    for (int k = 0; k < NCELL; k++) begin
      if (!(bus.wr_en === 1'b1 && int'(bus.wr_addr) == k &&
            bus.wr_data === 8'h20 && bus.busy === 1'b1))
        errs++;
      if (k == abort_at) begin
        aborted = 1'b1;
        break;
      end
      // Requests and characters offered mid-clear must be ignored.
      bus.clear_req  = 1'($urandom_range(0, 1));
      bus.char_valid = 1'($urandom_range(0, 1));
      bus.char_data  = 8'($urandom);
      #1;
      if (bus.char_ready !== 1'b0) errs++;
      @(posedge clk);
      @(negedge clk);
    end
    check_val("clear_writes", errs, 0);
    bus.clear_req  = 1'b0;
    bus.char_valid = 1'b0;
    mx = 0;
    my = 0;
    if (aborted) begin
      reset = 1'b1;
      #1;
      check_val("abort_wr_en", int'(bus.wr_en), 0);
      check_val("abort_busy", int'(bus.busy), 0);
      check_val("abort_wr_addr", int'(bus.wr_addr), 0);
      check_val("abort_cx", int'(bus.cursor_x), 0);
      check_val("abort_ready", int'(bus.char_ready), 1);
      @(negedge clk);
      reset = 1'b0;
    end else begin
      check_val("clear_end_wr_en", int'(bus.wr_en), 0);
      check_val("clear_end_busy", int'(bus.busy), 0);
      check_val("clear_end_cx", int'(bus.cursor_x), 0);
      check_val("clear_end_cy", int'(bus.cursor_y), 0);
    end
  endtask

  // One cycle of stimulus plus model update and checks. Called at a falling edge
  // with the console idle.
  task automatic step(input bit v, input logic [7:0] d, input bit c);
    bit  enter_clr;
    int  ew, ea, ed;
    bus.char_valid = v;
    bus.char_data  = d;
    bus.clear_req  = c;
    #1;
    check_val("char_ready", int'(bus.char_ready), c ? 0 : 1);
    ew = 0; ea = 0; ed = 0;
    enter_clr = c;
    if (v && !c) begin
      if (d >= 8'h20 && d <= 8'h7E) begin
        ew = 1; ea = my * COLS + mx; ed = int'(d);
        mx = mx + 1;
        if (mx == COLS) begin
          mx = 0;
          my = my + 1;
        end
      end else if (d == 8'h0A) begin
        mx = 0;
        my = my + 1;
      end else if (d == 8'h0D) begin
        mx = 0;
      end else if (d == 8'h08 && mx > 0) begin
        mx = mx - 1;
        ew = 1; ea = my * COLS + mx; ed = 32;
      end
      if (my == ROWS) begin
        my = 0;
`ifdef VGA_CONSOLE_AUTOCLEAR_EN
        enter_clr = 1'b1;
`endif
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (enter_clr) begin
      run_clear(-1);
    end else begin
      check_val("wr_en", int'(bus.wr_en), ew);
      if (ew != 0) begin
        check_val("wr_addr", int'(bus.wr_addr), ea);
        check_val("wr_data", int'(bus.wr_data), ed);
      end
      check_val("cursor_x", int'(bus.cursor_x), mx);
      check_val("cursor_y", int'(bus.cursor_y), my);
      check_val("busy", int'(bus.busy), 0);
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.char_valid = 1'b0;
    bus.char_data  = 8'h00;
    bus.clear_req  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check_val("rst_wr_en", int'(bus.wr_en), 0);
    check_val("rst_wr_addr", int'(bus.wr_addr), 0);
    check_val("rst_wr_data", int'(bus.wr_data), 0);
    check_val("rst_cx", int'(bus.cursor_x), 0);
    check_val("rst_cy", int'(bus.cursor_y), 0);
    check_val("rst_busy", int'(bus.busy), 0);
    reset = 1'b0;
    #1;
    check_val("post_rst_ready", int'(bus.char_ready), 1);

    // 'A' at home
    step(1'b1, 8'h41, 1'b0);
    check_val("a_addr", int'(bus.wr_addr), 0);
    check_val("a_data", int'(bus.wr_data), 8'h41);
    check_val("a_cx", int'(bus.cursor_x), 1);

    // Backspace at (3,2) and at (0,2)
    step(1'b1, 8'h0D, 1'b0);
    step(1'b1, 8'h0A, 1'b0);
    step(1'b1, 8'h0A, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'h61, 1'b0);
    step(1'b1, 8'h08, 1'b0);
    check_val("bs_wr_en", int'(bus.wr_en), 1);
    check_val("bs_addr", int'(bus.wr_addr), 322);
    check_val("bs_data", int'(bus.wr_data), 8'h20);
    check_val("bs_cx", int'(bus.cursor_x), 2);
    step(1'b1, 8'h0D, 1'b0);
    step(1'b1, 8'h08, 1'b0);
    check_val("bs0_wr_en", int'(bus.wr_en), 0);
    check_val("bs0_cx", int'(bus.cursor_x), 0);

    // End-of-row wrap at (159,5)
    for (int i = 0; i < 3; i++) step(1'b1, 8'h0A, 1'b0);
    for (int i = 0; i < COLS - 1; i++) step(1'b1, 8'(97 + i % 26), 1'b0);
    step(1'b1, 8'h42, 1'b0);
    check_val("eol_addr", int'(bus.wr_addr), 959);
    check_val("eol_cx", int'(bus.cursor_x), 0);
    check_val("eol_cy", int'(bus.cursor_y), 6);

    // Random stream, including idle gaps and back-to-back transfers
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 4) == 0) step(1'b0, 8'($urandom), 1'b0);
      else                           step(1'b1, rnd_char(), 1'b0);
    end

    // LF on the last row
    step(1'b1, 8'h0D, 1'b0);
    for (int i = 0; i < ROWS && my != ROWS - 1; i++) step(1'b1, 8'h0A, 1'b0);
    check_val("lastrow_cy", int'(bus.cursor_y), ROWS - 1);
    step(1'b1, 8'h0A, 1'b0);
`ifndef VGA_CONSOLE_AUTOCLEAR_EN
    check_val("wrap_cy", int'(bus.cursor_y), 0);
    check_val("wrap_wr_en", int'(bus.wr_en), 0);
`endif

    // Clear request beats a simultaneous character
    step(1'b1, 8'h20, 1'b0);
    step(1'b1, 8'h5A, 1'b1);
    step(1'b1, 8'h51, 1'b0);
    check_val("after_clear_addr", int'(bus.wr_addr), 0);
    check_val("after_clear_data", int'(bus.wr_data), 8'h51);

    // Reset in the middle of a clear aborts it for good
    bus.clear_req  = 1'b1;
    bus.char_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    run_clear(100);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h52, 1'b0);
    check_val("post_abort_addr", int'(bus.wr_addr), 0);
    step(1'b0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
